// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding fetch FSM, PC sequencing and a
// circular return-address stack with sticky overflow/underflow flags.
//
// state | meaning
// IDLE  | no fetch in flight, waiting for ldInst
// REQ   | request driven to instruction memory for one cycle
// WAIT  | waiting for imemValid
// DONE  | instruction captured, returning to IDLE
module fetch_unit #(
    parameter int          RAS_DEPTH = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ldInst,
    input  logic        clrInst,
    input  logic        ldPC,
    input  logic        clrPC,
    input  logic        isBranchTaken,
    input  logic        isCall,
    input  logic        isRet,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemValid,
    input  logic [31:0] imemData,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic [31:0] inst,
    output logic [4:0]  opcode,
    output logic        iOrReg,
    output logic [1:0]  modifier,
    output logic        instValid,
    output logic        rasOverflow,
    output logic        rasUnderflow
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] RAS_FULL = CW'(RAS_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t        state, state_nxt;
    logic [31:0]   addr_q;
    logic [31:0]   ras_mem [RAS_DEPTH];
    logic [PW-1:0] ras_top, ras_top_inc, ras_top_dec;
    logic [CW-1:0] ras_cnt;
    logic [31:0]   br_target, ras_pop_val;
    logic          capture, push, pop;

    assign npc         = pc + 32'd4;
    assign br_target   = npc + {{3{inst[26]}}, inst[26:0], 2'b00};
    assign opcode      = inst[31:27];
    assign iOrReg      = inst[26];
    assign modifier    = inst[17:16];

    assign ras_top_inc = ras_top + PW'(1);
    assign ras_top_dec = ras_top - PW'(1);
    assign ras_pop_val = (ras_cnt == '0) ? RESET_PC : ras_mem[ras_top];
    assign push        = ldPC && !clrPC && !isRet && isBranchTaken && isCall;
    assign pop         = ldPC && !clrPC && isRet;
    assign capture     = (state == WAIT) && imemValid && !clrInst;

    always_comb begin
        state_nxt = state;
        imemReq   = 1'b0;
        imemAddr  = addr_q;
        unique case (state)
            IDLE: if (ldInst) state_nxt = REQ;
            REQ: begin
                imemReq   = 1'b1;
                imemAddr  = pc;
                state_nxt = WAIT;
            end
            WAIT: if (imemValid) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clrInst) state_nxt = IDLE;
    end

    // addr_q holds the in-flight address so a PC update during WAIT cannot move it
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            inst      <= '0;
            instValid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == REQ) addr_q <= pc;
            if (clrInst) begin
                inst      <= '0;
                instValid <= 1'b0;
            end else if (capture) begin
                inst      <= imemData;
                instValid <= 1'b1;
            end else if (state == IDLE && ldInst) begin
                instValid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_PC;
            ras_top      <= '0;
            ras_cnt      <= '0;
            rasOverflow  <= 1'b0;
            rasUnderflow <= 1'b0;
        end else if (clrPC) begin
            pc      <= RESET_PC;
            ras_top <= '0;
            ras_cnt <= '0;
        end else if (ldPC) begin
            if (pop) begin
                pc <= ras_pop_val;
                if (ras_cnt == '0) begin
                    rasUnderflow <= 1'b1;
                end else begin
                    ras_top <= ras_top_dec;
                    ras_cnt <= ras_cnt - CW'(1);
                end
            end else if (isBranchTaken) begin
                pc <= br_target;
                if (push) begin
                    // a full stack drops its oldest entry by wrapping the top pointer
                    ras_top <= ras_top_inc;
                    if (ras_cnt == RAS_FULL) rasOverflow <= 1'b1;
                    else                     ras_cnt     <= ras_cnt + CW'(1);
                end
            end else begin
                pc <= npc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) ras_mem[ras_top_inc] <= npc;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a queue-based model.
module tb_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, ldInst, clrInst, ldPC, clrPC, isBranchTaken, isCall, isRet;
    logic        imemReq, imemValid, instValid, iOrReg, rasOverflow, rasUnderflow;
    logic [31:0] imemAddr, imemData, pc, npc, inst;
    logic [4:0]  opcode;
    logic [1:0]  modifier;

    fetch_unit #(.RAS_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .ldInst(ldInst), .clrInst(clrInst), .ldPC(ldPC),
        .clrPC(clrPC), .isBranchTaken(isBranchTaken), .isCall(isCall), .isRet(isRet),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemValid(imemValid),
        .imemData(imemData), .pc(pc), .npc(npc), .inst(inst), .opcode(opcode),
        .iOrReg(iOrReg), .modifier(modifier), .instValid(instValid),
        .rasOverflow(rasOverflow), .rasUnderflow(rasUnderflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // model: fetch phase 0 idle, 1 request, 2 waiting, 3 done
    bit          m_known = 1'b0;
    int          m_phase;
    logic [31:0] m_pc, m_inst;
    logic        m_valid, m_ovf, m_unf;
    logic [31:0] m_ras[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_model();
        if (!m_known) return;
        chk("pc", pc, m_pc);
        chk("npc", npc, m_pc + 32'd4);
        chk("inst", inst, m_inst);
        chk("opcode", 32'(opcode), m_inst / 32'h0800_0000);
        chk("iOrReg", 32'(iOrReg), (m_inst / 32'h0400_0000) % 2);
        chk("modifier", 32'(modifier), (m_inst / 32'h0001_0000) % 4);
        chk("instValid", 32'(instValid), 32'(m_valid));
        chk("imemReq", 32'(imemReq), 32'(m_phase == 1));
        if (m_phase == 1) chk("imemAddr", imemAddr, m_pc);
        chk("rasOverflow", 32'(rasOverflow), 32'(m_ovf));
        chk("rasUnderflow", 32'(rasUnderflow), 32'(m_unf));
    endtask

    task automatic model_step();
        logic [31:0] nx, tgt;
        int          off;
        if (rst) begin
            m_known = 1'b1;
            m_pc = RPC; m_inst = '0; m_valid = 1'b0; m_phase = 0;
            m_ras.delete(); m_ovf = 1'b0; m_unf = 1'b0;
            return;
        end
        nx  = m_pc + 32'd4;
        off = int'(m_inst[26:0]);
        if (m_inst[26]) off = off - (1 << 27);
        tgt = nx + 32'(off * 4);
        if (clrPC) begin
            m_pc = RPC;
            m_ras.delete();
        end else if (ldPC) begin
            if (isRet) begin
                if (m_ras.size() == 0) begin
                    m_pc  = RPC;
                    m_unf = 1'b1;
                end else begin
                    m_pc = m_ras.pop_back();
                end
            end else if (isBranchTaken) begin
                if (isCall) begin
                    m_ras.push_back(nx);
                    if (m_ras.size() > DEPTH) begin
                        void'(m_ras.pop_front());
                        m_ovf = 1'b1;
                    end
                end
                m_pc = tgt;
            end else begin
                m_pc = nx;
            end
        end
        case (m_phase)
            0: if (ldInst) begin m_phase = 1; m_valid = 1'b0; end
            1: m_phase = 2;
            2: if (imemValid) begin m_inst = imemData; m_valid = 1'b1; m_phase = 3; end
            default: m_phase = 0;
        endcase
        if (clrInst) begin
            m_inst = '0; m_valid = 1'b0; m_phase = 0;
        end
    endtask

    task automatic step(input logic r, li, ci, lp, cp, b, c, rt, v, input logic [31:0] d);
        @(negedge clk);
        check_model();
        rst = r; ldInst = li; clrInst = ci; ldPC = lp; clrPC = cp;
        isBranchTaken = b; isCall = c; isRet = rt; imemValid = v; imemData = d;
        model_step();
    endtask

    task automatic idle1();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic ldpc(input logic b, c, rt);
        step(0, 0, 0, 1, 0, b, c, rt, 0, 32'h0);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ldInst = 0; clrInst = 0; ldPC = 0; clrPC = 0;
        isBranchTaken = 0; isCall = 0; isRet = 0; imemValid = 0; imemData = '0;

        // reset state
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        settle();
        chk("rst_pc", pc, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_instValid", 32'(instValid), 32'h0);
        chk("rst_imemReq", 32'(imemReq), 32'h0);
        chk("rst_imemAddr", imemAddr, 32'h0);

        // sequential fetch, zero-wait memory: instValid three edges after ldInst
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        settle();
        chk("seq_req", 32'(imemReq), 32'h1);
        chk("seq_addr", imemAddr, 32'h0);
        idle1();
        settle();
        chk("seq_wait_novalid", 32'(instValid), 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0800_0000);
        settle();
        chk("seq_inst", inst, 32'h0800_0000);
        chk("seq_opcode", 32'(opcode), 32'h1);
        chk("seq_instValid", 32'(instValid), 32'h1);
        ldpc(0, 0, 0);
        settle();
        chk("seq_pc", pc, 32'h4);

        // taken branch at pc=8 with offset -2
        ldpc(0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        idle1();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h07FF_FFFE);
        ldpc(1, 0, 0);
        settle();
        chk("br_pc", pc, 32'h4);
        chk("br_model_pc", m_pc, 32'h4);

        // call at pc=16 pushes 20, return pops it
        ldpc(0, 0, 0); ldpc(0, 0, 0); ldpc(0, 0, 0);
        settle();
        chk("call_start_pc", pc, 32'h10);
        ldpc(1, 1, 0);
        settle();
        chk("call_pc", pc, 32'hC);
        ldpc(0, 1, 1);
        settle();
        chk("ret_pc", pc, 32'h14);

        // five calls into a depth-4 stack, then five returns
        for (int i = 0; i < 5; i++) begin
            ldpc(1, 1, 0);
            settle();
            chk("ovf_flag", 32'(rasOverflow), (i == 4) ? 32'h1 : 32'h0);
        end
        for (int i = 0; i < 4; i++) ldpc(0, 0, 1);
        settle();
        chk("ret4_pc", pc, 32'h14);
        chk("ret4_unf", 32'(rasUnderflow), 32'h0);
        ldpc(0, 0, 1);
        settle();
        chk("ret5_pc", pc, RPC);
        chk("ret5_unf", 32'(rasUnderflow), 32'h1);
        chk("ret5_ovf_sticky", 32'(rasOverflow), 32'h1);

        // ldPC during WAIT keeps the fetch address
        ldpc(0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        idle1();
        ldpc(0, 0, 0);
        settle();
        chk("wait_addr_held", imemAddr, 32'h4);
        chk("wait_pc_moved", pc, 32'h8);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678);
        settle();
        chk("wait_inst", inst, 32'h1234_5678);

        // clrInst in WAIT, then a late imemValid
        idle1();
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        idle1();
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        settle();
        chk("abort_inst", inst, 32'h0);
        chk("abort_instValid", 32'(instValid), 32'h0);
        chk("abort_imemReq", 32'(imemReq), 32'h0);

        // rst while in REQ
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        settle();
        chk("rstreq_req_before", 32'(imemReq), 32'h1);
        step(1, 0, 0, 1, 0, 1, 1, 0, 1, 32'h0);
        settle();
        chk("rstreq_imemReq", 32'(imemReq), 32'h0);
        chk("rstreq_pc", pc, RPC);
        chk("rstreq_ovf", 32'(rasOverflow), 32'h0);
        chk("rstreq_unf", 32'(rasUnderflow), 32'h0);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 1) == 0,
                 $urandom_range(0, 1) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 0,
                 $urandom());
        end
        @(negedge clk);
        check_model();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
